// File: rtl/cp0_regfile_if.sv
// CP0 register file bus: exception write-back inputs, MTC0/MFC0 access and
// the registered CP0 state returned to the exception logic.
interface cp0_regfile_if;
   logic [31:0] exc_we;
   logic        exception_occur;
   logic        eret;
   logic [31:0] new_EPC;
   logic [31:0] new_BadVAddr;
   logic [4:0]  new_ExcCode;
   logic        new_BD;
   logic [5:0]  hw_int;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic [4:0]  mfc0_addr;
   logic [31:0] mfc0_rdata;
   logic [31:0] Status;
   logic [31:0] Cause;
   logic [31:0] EPC;
   logic [31:0] BadVAddr;
   logic        timer_int;

   modport master (
      output exc_we, exception_occur, eret, new_EPC, new_BadVAddr, new_ExcCode,
             new_BD, hw_int, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
      input  mfc0_rdata, Status, Cause, EPC, BadVAddr, timer_int
   );

   modport slave (
      input  exc_we, exception_occur, eret, new_EPC, new_BadVAddr, new_ExcCode,
             new_BD, hw_int, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
      output mfc0_rdata, Status, Cause, EPC, BadVAddr, timer_int
   );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: EPC/BadVAddr/Cause/Status plus MTC0/MFC0 access.
// Define CP0_TIMER_EN to build the Count/Compare timer (Cause.TI on HW line 5).
module cp0_regfile #(
   parameter logic [31:0] STATUS_RST = 32'h0040_0000,
   parameter int          COUNT_DIV  = 2
) (
   input logic          clk,
   input logic          rst,
   cp0_regfile_if.slave bus
);
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   logic [31:0] status_q, cause_q, epc_q, badvaddr_q;
   logic        mtc0_en, ti;

   // A flushed (excepting) instruction must not commit its MTC0.
   assign mtc0_en = bus.mtc0_we & ~bus.exception_occur;

`ifdef CP0_TIMER_EN
   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic [31:0]      count_q, compare_q;
   logic             count_wr, compare_wr;

   assign count_wr   = mtc0_en && (bus.mtc0_addr == 5'd9);
   assign compare_wr = mtc0_en && (bus.mtc0_addr == 5'd11);
   assign ti         = cause_q[30];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
      end else begin
         if (count_wr) begin
            count_q <= bus.mtc0_wdata;
            div_q   <= '0;
         end else if (div_q == DIV_W'(COUNT_DIV - 1)) begin
            div_q   <= '0;
            count_q <= count_q + 32'd1;
         end else begin
            div_q <= div_q + 1'b1;
         end
         if (compare_wr) compare_q <= bus.mtc0_wdata;
      end
   end
`else
   logic unused_div;
   assign ti         = 1'b0;
   assign unused_div = ^32'(COUNT_DIV);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q   <= STATUS_RST;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         if (mtc0_en && bus.mtc0_addr == 5'd12)
            status_q <= (status_q & ~STATUS_WMASK) | (bus.mtc0_wdata & STATUS_WMASK);
         // EXL update follows the MTC0 so eret overrides a same-cycle write.
         if (bus.exc_we[12]) begin
            if (bus.exception_occur) status_q[1] <= 1'b1;
            else if (bus.eret)       status_q[1] <= 1'b0;
         end

         if (mtc0_en && bus.mtc0_addr == 5'd13) cause_q[9:8] <= bus.mtc0_wdata[9:8];
         if (bus.exc_we[13] && bus.exception_occur) begin
            cause_q[31]  <= bus.new_BD;
            cause_q[6:2] <= bus.new_ExcCode;
         end
         cause_q[15:10] <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
`ifdef CP0_TIMER_EN
         // Compare write acknowledges the interrupt and beats a same-cycle match.
         if (compare_wr)                  cause_q[30] <= 1'b0;
         else if (count_q == compare_q)   cause_q[30] <= 1'b1;
`endif

         if (mtc0_en && bus.mtc0_addr == 5'd14) epc_q <= bus.mtc0_wdata;
         if (bus.exc_we[14])                    epc_q <= bus.new_EPC;

         if (bus.exc_we[8]) badvaddr_q <= bus.new_BadVAddr;
      end
   end

   always_comb begin
      bus.mfc0_rdata = '0;
      case (bus.mfc0_addr)
         5'd8:  bus.mfc0_rdata = badvaddr_q;
`ifdef CP0_TIMER_EN
         5'd9:  bus.mfc0_rdata = count_q;
         5'd11: bus.mfc0_rdata = compare_q;
`endif
         5'd12: bus.mfc0_rdata = status_q;
         5'd13: bus.mfc0_rdata = cause_q;
         5'd14: bus.mfc0_rdata = epc_q;
         default: bus.mfc0_rdata = '0;
      endcase
   end

   assign bus.Status    = status_q;
   assign bus.Cause     = cause_q;
   assign bus.EPC       = epc_q;
   assign bus.BadVAddr  = badvaddr_q;
   assign bus.timer_int = cause_q[30];

   logic unused_ok;
   assign unused_ok = &{1'b0, bus.exc_we[31:15], bus.exc_we[11:9], bus.exc_we[7:0]};
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile; timer checks build only with CP0_TIMER_EN.
module tb_cp0_regfile;
   logic clk, rst;
   int   checks, errors;

   cp0_regfile_if bus();

   cp0_regfile #(.STATUS_RST(32'h0040_0000), .COUNT_DIV(2)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.exc_we = '0; bus.exception_occur = 0; bus.eret = 0;
      bus.new_EPC = '0; bus.new_BadVAddr = '0; bus.new_ExcCode = '0; bus.new_BD = 0;
      bus.hw_int = '0; bus.mtc0_we = 0; bus.mtc0_addr = '0; bus.mtc0_wdata = '0;
      bus.mfc0_addr = '0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.mtc0_we = 1; bus.mtc0_addr = a; bus.mtc0_wdata = d;
      tick();
      bus.mtc0_we = 0;
   endtask

   task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
      bus.mfc0_addr = a;
      #1;
      d = bus.mfc0_rdata;
   endtask

   // Reset leaves Count == Compare == 0, which raises TI; park Compare out of reach.
   task automatic timer_park();
`ifdef CP0_TIMER_EN
      mtc0(5'd11, 32'hFFFF_FFFF);
      tick();
      tick();
`endif
   endtask

   task automatic test_reset();
      checks++; if (bus.Status !== 32'h0040_0000) begin errors++; $display("FAIL reset_status got %h exp %h", bus.Status, 32'h0040_0000); end
      checks++; if (bus.Cause !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", bus.Cause); end
      checks++; if (bus.EPC !== 32'h0 || bus.BadVAddr !== 32'h0) begin errors++; $display("FAIL reset_epc_bva got %h/%h exp 0/0", bus.EPC, bus.BadVAddr); end
      checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL reset_ti got %b exp 0", bus.timer_int); end
   endtask

   task automatic test_async_reset();
      mtc0(5'd14, 32'h0000_1234);
      mtc0(5'd12, 32'h0000_0001);
      checks++; if (bus.EPC !== 32'h1234) begin errors++; $display("FAIL pre_reset_epc got %h exp 1234", bus.EPC); end
      #3 rst = 1;          // clk high, no edge until after the checks
      #1;
      checks++; if (bus.EPC !== 32'h0) begin errors++; $display("FAIL async_reset_epc got %h exp 0", bus.EPC); end
      checks++; if (bus.Status !== 32'h0040_0000) begin errors++; $display("FAIL async_reset_status got %h exp 00400000", bus.Status); end
      #2 rst = 0;
      tick();
      timer_park();
   endtask

   task automatic test_status_mask();
      logic [31:0] r;
      mtc0(5'd12, 32'hFFFF_FFFF);
      checks++; if (bus.Status !== 32'h0040_FF03) begin errors++; $display("FAIL status_mask got %h exp 0040ff03", bus.Status); end
      mfc0(5'd12, r);
      checks++; if (r !== 32'h0040_FF03) begin errors++; $display("FAIL mfc0_status got %h exp 0040ff03", r); end
      mtc0(5'd12, 32'h0);
      checks++; if (bus.Status !== 32'h0040_0000) begin errors++; $display("FAIL status_clear got %h exp 00400000", bus.Status); end
   endtask

   task automatic test_cause_mask();
      logic [31:0] r;
      mtc0(5'd13, 32'hFFFF_FFFF);
      checks++; if (bus.Cause !== 32'h0000_0300) begin errors++; $display("FAIL cause_mask got %h exp 00000300", bus.Cause); end
      mfc0(5'd13, r);
      checks++; if (r !== 32'h0000_0300) begin errors++; $display("FAIL mfc0_cause got %h exp 00000300", r); end
   endtask

   task automatic test_exception();
      bus.exception_occur = 1; bus.exc_we = 32'h0000_7100;
      bus.new_EPC = 32'hBFC0_0100; bus.new_BadVAddr = 32'h3;
      bus.new_ExcCode = 5'h04; bus.new_BD = 1;
      bus.mtc0_we = 1; bus.mtc0_addr = 5'd14; bus.mtc0_wdata = 32'h1234;
      tick();
      idle_inputs();
      checks++; if (bus.EPC !== 32'hBFC0_0100) begin errors++; $display("FAIL exc_epc got %h exp bfc00100", bus.EPC); end
      checks++; if (bus.BadVAddr !== 32'h3) begin errors++; $display("FAIL exc_badvaddr got %h exp 3", bus.BadVAddr); end
      checks++; if (bus.Cause !== 32'h8000_0310) begin errors++; $display("FAIL exc_cause got %h exp 80000310", bus.Cause); end
      checks++; if (bus.Status !== 32'h0040_0002) begin errors++; $display("FAIL exc_status got %h exp 00400002", bus.Status); end
   endtask

   task automatic test_eret();
      bus.eret = 1; bus.exc_we = 32'h0000_1000;
      tick();
      idle_inputs();
      checks++; if (bus.Status !== 32'h0040_0000) begin errors++; $display("FAIL eret_status got %h exp 00400000", bus.Status); end
      checks++; if (bus.EPC !== 32'hBFC0_0100) begin errors++; $display("FAIL eret_epc got %h exp bfc00100", bus.EPC); end
      // eret and MTC0 Status together: IM/IE written, EXL cleared by eret
      bus.eret = 1; bus.exc_we = 32'h0000_1000;
      bus.mtc0_we = 1; bus.mtc0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_FF03;
      tick();
      idle_inputs();
      checks++; if (bus.Status !== 32'h0040_FF01) begin errors++; $display("FAIL eret_mtc0_status got %h exp 0040ff01", bus.Status); end
      mtc0(5'd12, 32'h0);
   endtask

   task automatic test_hw_int();
      logic [31:0] r;
      bus.hw_int = 6'b000101;
      tick();
      checks++; if (bus.Cause !== 32'h8000_1710) begin errors++; $display("FAIL hw_sample got %h exp 80001710", bus.Cause); end
      mfc0(5'd10, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL mfc0_reg10 got %h exp 0", r); end
      mfc0(5'd8, r);
      checks++; if (r !== 32'h3) begin errors++; $display("FAIL mfc0_badvaddr got %h exp 3", r); end
      bus.hw_int = 6'b0;
      tick();
      checks++; if (bus.Cause[15:10] !== 6'b0) begin errors++; $display("FAIL hw_clear got %b exp 000000", bus.Cause[15:10]); end
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      logic [31:0] r;
      mtc0(5'd9, 32'h0);            // edge 0: Count=0, divider cleared
      mtc0(5'd11, 32'd5);           // edge 1
      for (int i = 0; i < 8; i++) tick();
      checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL ti_early got %b exp 0", bus.timer_int); end
      tick();                       // edge 10: Count reaches 5
      mfc0(5'd9, r);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL count_val got %0d exp 5", r); end
      checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL ti_match_cycle got %b exp 0", bus.timer_int); end
      tick();
      checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL ti_rise got %b exp 1", bus.timer_int); end
      tick();
      checks++; if (bus.Cause[15] !== 1'b1) begin errors++; $display("FAIL ti_ip7 got %b exp 1", bus.Cause[15]); end
      tick();
      checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL ti_hold got %b exp 1", bus.timer_int); end
      mtc0(5'd11, 32'd100);
      checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL ti_clear got %b exp 0", bus.timer_int); end
      tick();
      checks++; if (bus.Cause[15] !== 1'b0) begin errors++; $display("FAIL ti_ip7_clear got %b exp 0", bus.Cause[15]); end
   endtask
`else
   task automatic test_timer_disabled();
      logic [31:0] r;
      mtc0(5'd9, 32'h55);
      mtc0(5'd11, 32'h55);
      tick();
      mfc0(5'd9, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL count_absent got %h exp 0", r); end
      mfc0(5'd11, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL compare_absent got %h exp 0", r); end
      checks++; if (bus.timer_int !== 1'b0 || bus.Cause[30] !== 1'b0) begin errors++; $display("FAIL ti_absent got %b exp 0", bus.timer_int); end
   endtask
`endif

   initial begin
      checks = 0; errors = 0;
      rst = 1;
      idle_inputs();
      #1;
      test_reset();
      #21 rst = 0;
      tick();
      timer_park();
      test_async_reset();
      test_status_mask();
      test_cause_mask();
      test_exception();
      test_eret();
      test_hw_int();
`ifdef CP0_TIMER_EN
      test_timer();
`else
      test_timer_disabled();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file directly downstream of the exception decision logic in the write-back stage.
- Registers the CP0 state that logic produces: EPC, BadVAddr, Cause.ExcCode/BD, Status.EXL.
- Services MTC0/MFC0 and owns the Count/Compare timer.
- Returns Status, Cause and EPC to the exception logic, and raises the timer interrupt on hardware line 5.

Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).
- COUNT_DIV, 2, cycles per Count increment.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- exc_we  in  32  per-register exception write enables (bit n = CP0 reg n; bits 8, 12, 13, 14 used).
- exception_occur  in  1  exception taken this cycle.
- eret  in  1  ERET retiring this cycle.
- new_EPC  in  32  EPC value.
- new_BadVAddr  in  32  faulting address.
- new_ExcCode  in  5  exception code.
- new_BD  in  1  delay-slot flag.
- hw_int  in  6  external interrupt lines.
- mtc0_we  in  1  MTC0 write strobe.
- mtc0_addr  in  5  MTC0 register number (sel fixed 0).
- mtc0_wdata  in  32  MTC0 data.
- mfc0_addr  in  5  MFC0 register number.
- mfc0_rdata  out  32  MFC0 read data.
- Status  out  32  current Status.
- Cause  out  32  current Cause.
- EPC  out  32  current EPC.
- BadVAddr  out  32  current BadVAddr.
- timer_int  out  1  Cause.TI.

Behaviour:
- Reset: asynchronous, active-high. Values on reset:
  - Status = STATUS_RST.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Divider counter = 0; timer_int = 0.
- All register updates occur on posedge clk.
- Outputs are registered values. mfc0_rdata is combinational from the registers, with no same-cycle MTC0 bypass; the pipeline resolves that hazard.
- MFC0 read map:
  - reg 8 = BadVAddr, 9 = Count, 11 = Compare, 12 = Status, 13 = Cause, 14 = EPC.
  - Any other address reads 0.
- MTC0 writable bits; other bits hold:
  - Status [15:8] IM, [1] EXL, [0] IE.
  - Cause [9:8] software IP.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr and Cause other bits: read-only.
- Exception writes (enables gated by exc_we):
  - exc_we[14]: EPC <= new_EPC.
  - exc_we[8]: BadVAddr <= new_BadVAddr.
  - exc_we[13] with exception_occur: Cause[31] <= new_BD, Cause[6:2] <= new_ExcCode.
  - exc_we[12]: Status[1] <= 1 if exception_occur, else <= 0 if eret.
- Priority:
  - exception_occur=1 suppresses any MTC0 in the same cycle, to any register, because the instruction is flushed.
  - eret with mtc0_we: both apply; eret wins on Status.EXL.
- Hardware IP: every cycle Cause[15:10] <= {hw_int[5] | Cause[30], hw_int[4:0]}, a 1-cycle registered sample.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count increments when the divider wraps. Count wraps 32'hFFFF_FFFF -> 0.
  - MTC0 to Count loads the value and clears the divider.
  - Cause[30] (TI) sets the cycle after Count == Compare is observed. It stays set until MTC0 to Compare.
  - A Compare write clears TI, and the clear beats a same-cycle set.
- Reset asserted mid-operation restores all reset values immediately, independent of clk.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare and TI operate as above.
- Undefined:
  - No Count/Compare storage; regs 9/11 read 0 and MTC0 to them is ignored.
  - Cause[30] and timer_int stay 0.
  - Cause[15] = registered hw_int[5] only.

Test Plan:
- Reset check: assert rst mid-cycle -> Status=32'h0040_0000 and all other outputs 0 with no clock edge.
- MTC0 Status masking: MTC0 Status 32'hFFFF_FFFF -> reads 32'h0040_FF03.
- MTC0 Cause masking: MTC0 Cause 32'hFFFF_FFFF -> Cause[9:8]=2'b11 and the rest 0, with hw_int=0.
- Exception vs MTC0: exception_occur=1, exc_we bits 8/12/13/14 set, new_EPC=32'hBFC0_0100, new_BadVAddr=32'h0000_0003, new_ExcCode=5'h04, new_BD=1, same-cycle MTC0 EPC=32'h1234 -> next cycle:
  - EPC=32'hBFC0_0100.
  - BadVAddr=32'h3.
  - Cause[6:2]=4, Cause[31]=1.
  - Status[1]=1.
- ERET: eret=1, exc_we[12]=1 with EXL=1 -> Status[1]=0 next cycle; EPC unchanged.
- Timer (CP0_TIMER_EN): MTC0 Compare=5, MTC0 Count=0 -> timer_int rises about 11 cycles later (Count hits 5 at cycle 10 with COUNT_DIV=2). Holds until MTC0 Compare=100, then drops next cycle; hw_int=0 while Cause[15] follows TI.
- Interrupt sampling: hw_int=6'b000101 -> Cause[15:10]=6'b000101 one cycle later; MFC0 reg 10 returns 0.
